// File: rtl/mem_access_ctrl_if.sv
// CPU request/response plus ram256x8 MOV/MOC bus bundle used by mem_access_ctrl.
// master = the controller side, slave = CPU control unit + RAM side.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        MOV;
  logic        ReadWrite;
  logic [2:0]  MS_2_0;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic        MOC;
  logic [31:0] DataOut;

  modport master (
    input  req_valid, req_rw, req_size, req_addr, req_wdata, MOC, DataOut,
    output req_ready, resp_valid, resp_err, resp_rdata,
           MOV, ReadWrite, MS_2_0, Address, DataIn
  );

  modport slave (
    output req_valid, req_rw, req_size, req_addr, req_wdata, MOC, DataOut,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           MOV, ReadWrite, MS_2_0, Address, DataIn
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store master for the ram256x8 MOV/MOC handshake with timeout and size extension.
// Optional: define ALIGN_CHECK_EN to reject misaligned half/word requests before any MOV.

module mem_access_ctrl_lane #(
  parameter int VEC_W = 8
) (
  input  logic [VEC_W-1:0] wbyte,
  input  logic [VEC_W-1:0] rbyte,
  input  logic [VEC_W-1:0] fill,
  input  logic             w_en,
  input  logic             r_en,
  output logic [VEC_W-1:0] wout,
  output logic [VEC_W-1:0] rout
);
  assign wout = w_en ? wbyte : '0;
  assign rout = r_en ? rbyte : fill;
endmodule

module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic               CLK,
  input  logic               RESET_N,
  mem_access_ctrl_if.master  bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_RELEASE, S_RESP} state_t;

  typedef struct packed {
    logic        rw;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            mov_q, mov_d;
  logic            rw_q, rw_d;
  logic [2:0]      ms_q, ms_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     din_q, din_d;
  logic            sext_q, sext_d;
  logic            err_q, err_d;
  logic [31:0]     ld_q, ld_d;
  logic            ready_q, ready_d;
  logic            rvalid_q, rvalid_d;
  resp_t           resp_q, resp_d;

  req_t                             req_in;
  logic                             accept, bad_req, to_hit, rsign;
  logic [NUM_LANES-1:0]             w_en, r_en;
  logic [VEC_W-1:0]                 fill;
  logic [NUM_LANES-1:0][VEC_W-1:0]  wdata_l, rdata_l, din_m, rd_ext;

  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign req_in  = '{rw: bus.req_rw, size: bus.req_size, addr: bus.req_addr, wdata: bus.req_wdata};
  assign accept  = bus.req_valid & ready_q;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign to_hit  = (cnt_inc >= TO_W'(TIMEOUT_CYCLES));

  always_comb begin
    bad_req = (req_in.size[1:0] == 2'b11);
`ifdef ALIGN_CHECK_EN
    if (req_in.size[1:0] == 2'b01 && req_in.addr[0])          bad_req = 1'b1;
    if (req_in.size[1:0] == 2'b10 && req_in.addr[1:0] != 2'b00) bad_req = 1'b1;
`endif
  end

  // Write lanes use the incoming size; read lanes use the size latched on the bus.
  assign w_en    = lane_mask(req_in.size[1:0]);
  assign r_en    = lane_mask(ms_q[1:0]);
  assign rsign   = (ms_q[1:0] == 2'b00) ? bus.DataOut[7] : bus.DataOut[15];
  assign fill    = {VEC_W{sext_q & rsign}};
  assign wdata_l = req_in.wdata;
  assign rdata_l = bus.DataOut;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_access_ctrl_lane #(.VEC_W(VEC_W)) u_lane (
      .wbyte (wdata_l[g]),
      .rbyte (rdata_l[g]),
      .fill  (fill),
      .w_en  (w_en[g]),
      .r_en  (r_en[g]),
      .wout  (din_m[g]),
      .rout  (rd_ext[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mov_d    = mov_q;
    rw_d     = rw_q;
    ms_d     = ms_q;
    addr_d   = addr_q;
    din_d    = din_q;
    sext_d   = sext_q;
    err_d    = err_q;
    ld_d     = ld_q;
    ready_d  = ready_q;
    rvalid_d = 1'b0;
    resp_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          if (bad_req) begin
            state_d    = S_RESP;
            rvalid_d   = 1'b1;
            resp_d.err = 1'b1;
          end else begin
            state_d = S_SETUP;
            rw_d    = req_in.rw;
            ms_d    = {1'b0, req_in.size[1:0]};
            addr_d  = req_in.addr;
            din_d   = din_m;
            sext_d  = req_in.size[2] & req_in.rw;
            err_d   = 1'b0;
            ld_d    = '0;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        mov_d   = 1'b1;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        cnt_d = cnt_inc;
        if (bus.MOC) begin
          state_d = S_RELEASE;
          mov_d   = 1'b0;
          cnt_d   = '0;
          ld_d    = rw_q ? rd_ext : '0;
        end else if (to_hit) begin
          state_d = S_RELEASE;
          mov_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_inc;
        // MOC dropping on the last allowed cycle still counts as a clean finish.
        if (!bus.MOC || to_hit) begin
          state_d      = S_RESP;
          cnt_d        = '0;
          rvalid_d     = 1'b1;
          resp_d.err   = err_q | bus.MOC;
          resp_d.rdata = (err_q | bus.MOC) ? '0 : ld_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        mov_d   = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mov_q    <= 1'b0;
      rw_q     <= 1'b1;
      ms_q     <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      sext_q   <= 1'b0;
      err_q    <= 1'b0;
      ld_q     <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mov_q    <= mov_d;
      rw_q     <= rw_d;
      ms_q     <= ms_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      sext_q   <= sext_d;
      err_q    <= err_d;
      ld_q     <= ld_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      resp_q   <= resp_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_err   = resp_q.err;
  assign bus.resp_rdata = resp_q.rdata;
  assign bus.MOV        = mov_q;
  assign bus.ReadWrite  = rw_q;
  assign bus.MS_2_0     = ms_q;
  assign bus.Address    = addr_q;
  assign bus.DataIn     = din_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: RAM responder, shadow-memory reference model, scenario tasks.
module tb_mem_access_ctrl;
`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk, rst_n;
  mem_access_ctrl_if bus();
  mem_access_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (.CLK(clk), .RESET_N(rst_n), .bus(bus));

  int n_vec, n_err;
  int moc_mode, max_dly;                 // 0 normal, 1 MOC tied 0, 2 MOC tied 1
  logic [7:0] ram    [256];
  logic [7:0] shadow [256];
  int op_cnt, mov_rises, mov_cycles, unstable;
  logic [31:0] op_addr, op_din;
  logic [2:0]  op_ms;
  logic        op_rw;

  initial begin clk = 0; forever #5 clk = ~clk; end

  // RAM responder
  initial begin : ram_model
    int adly, rdly, nb;
    adly = -1; rdly = -1; op_cnt = 0;
    op_addr = 0; op_din = 0; op_ms = 0; op_rw = 0;
    bus.MOC = 0; bus.DataOut = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 11);
    forever begin
      @(negedge clk);
      if (moc_mode == 1 || moc_mode == 2) begin
        bus.MOC = (moc_mode == 2); adly = -1; rdly = -1;
      end else if (bus.MOV && !bus.MOC) begin
        if (adly < 0) adly = int'($urandom_range(0, max_dly));
        if (adly > 0) adly--;
        else begin
          nb = (bus.MS_2_0[1:0] == 2'b00) ? 1 : (bus.MS_2_0[1:0] == 2'b01) ? 2 : 4;
          op_addr = bus.Address; op_ms = bus.MS_2_0; op_rw = bus.ReadWrite; op_din = bus.DataIn;
          if (bus.ReadWrite) begin
            bus.DataOut = $urandom;
            for (int i = 0; i < nb; i++) bus.DataOut[8*i +: 8] = ram[8'(bus.Address + 32'(i))];
          end else begin
            for (int i = 0; i < nb; i++) ram[8'(bus.Address + 32'(i))] = bus.DataIn[8*i +: 8];
          end
          op_cnt++;
          bus.MOC = 1; adly = -1;
        end
      end else if (!bus.MOV && bus.MOC) begin
        if (rdly < 0) rdly = int'($urandom_range(0, max_dly));
        if (rdly > 0) rdly--;
        else begin bus.MOC = 0; bus.DataOut = $urandom; rdly = -1; end
      end
    end
  end

  // MOV monitor: rises, high cycles, bus stability while MOV is high
  initial begin : mov_mon
    logic mov_prev;
    logic [67:0] prev;
    mov_prev = 0; prev = 0; mov_rises = 0; mov_cycles = 0; unstable = 0;
    forever begin
      @(negedge clk);
      if (bus.MOV && !mov_prev) mov_rises++;
      if (bus.MOV) mov_cycles++;
      if (bus.MOV && mov_prev && prev != {bus.Address, bus.MS_2_0, bus.ReadWrite, bus.DataIn}) unstable++;
      mov_prev = bus.MOV;
      prev = {bus.Address, bus.MS_2_0, bus.ReadWrite, bus.DataIn};
    end
  end

  // Reference model
  function automatic logic exp_err(input logic [2:0] sz, input logic [31:0] a);
    logic mis;
    mis = (sz[1:0] == 2'b01 && a[0]) || (sz[1:0] == 2'b10 && a[1:0] != 2'b00);
    return (sz[1:0] == 2'b11) || (ALIGN && mis);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] v;
    int nb;
    v = 0; nb = nbytes(sz[1:0]);
    for (int i = 0; i < nb; i++) v = v | (32'(shadow[8'(a + 32'(i))]) << (8 * i));
    if (sz[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 1);
    return v;
  endfunction

  function automatic logic [31:0] masked(input logic [31:0] wd, input logic [1:0] sz);
    return (sz == 2'b00) ? (wd & 32'hFF) : (sz == 2'b01) ? (wd & 32'hFFFF) : wd;
  endfunction

  task automatic model_store(input logic rw, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    if (!rw && !exp_err(sz, a))
      for (int i = 0; i < nbytes(sz[1:0]); i++) shadow[8'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  // One request; a missed handshake returns X so the caller's err check fails.
  task automatic do_req(input logic rw, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        output logic e, output logic [31:0] rd, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid = 1; bus.req_rw = rw; bus.req_size = sz; bus.req_addr = a; bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin bus.req_valid = 0; e = 1'bx; rd = 'x; lat = -1; return; end
    @(negedge clk);
    bus.req_valid = 0; bus.req_rw = 1'($urandom); bus.req_size = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!bus.resp_valid) begin e = 1'bx; rd = 'x; lat = -1; end
    else begin e = bus.resp_err; rd = bus.resp_rdata; end
  endtask

  task automatic test_reset();
    rst_n = 1; #2 rst_n = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.MOV, bus.ReadWrite, bus.MS_2_0, bus.resp_valid, bus.resp_err, bus.req_ready} !== 8'b0100_0001) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 01000001",
               {bus.MOV, bus.ReadWrite, bus.MS_2_0, bus.resp_valid, bus.resp_err, bus.req_ready});
    end
    n_vec++;
    if (bus.Address !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", bus.Address); end
    n_vec++;
    if (bus.DataIn !== 32'h0) begin n_err++; $display("FAIL reset_datain got %h want 0", bus.DataIn); end
    n_vec++;
    if (bus.resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", bus.resp_rdata); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_spec_vectors();
    logic e; logic [31:0] rd; int lat, c0;
    moc_mode = 0; max_dly = 2;
    do_req(0, 3'b000, 32'd5, 32'hFFFFFF85, e, rd, lat); model_store(0, 3'b000, 32'd5, 32'hFFFFFF85);
    n_vec++;
    if ({e, rd, op_din} !== {1'b0, 32'h0, 32'h85}) begin
      n_err++; $display("FAIL byte_store got err=%b rd=%h din=%h want 0/0/85", e, rd, op_din);
    end
    do_req(1, 3'b000, 32'd5, 32'h0, e, rd, lat);
    n_vec++;
    if ({e, rd, op_ms} !== {1'b0, 32'h00000085, 3'b000}) begin
      n_err++; $display("FAIL ubyte_read got err=%b rd=%h ms=%b want 0/00000085/000", e, rd, op_ms);
    end
    do_req(1, 3'b100, 32'd5, 32'h0, e, rd, lat);
    n_vec++;
    if ({e, rd} !== {1'b0, 32'hFFFFFF85}) begin n_err++; $display("FAIL sbyte_read got %b/%h want 0/FFFFFF85", e, rd); end
    do_req(0, 3'b101, 32'd14, 32'h12348001, e, rd, lat); model_store(0, 3'b101, 32'd14, 32'h12348001);
    n_vec++;
    if ({e, op_din, op_ms} !== {1'b0, 32'h00008001, 3'b001}) begin
      n_err++; $display("FAIL half_store got err=%b din=%h ms=%b want 0/00008001/001", e, op_din, op_ms);
    end
    do_req(1, 3'b101, 32'd14, 32'h0, e, rd, lat);
    n_vec++;
    if ({e, rd} !== {1'b0, 32'hFFFF8001}) begin n_err++; $display("FAIL shalf_read got %b/%h want 0/FFFF8001", e, rd); end
    do_req(1, 3'b001, 32'd14, 32'h0, e, rd, lat);
    n_vec++;
    if ({e, rd} !== {1'b0, 32'h00008001}) begin n_err++; $display("FAIL uhalf_read got %b/%h want 0/00008001", e, rd); end
    c0 = op_cnt;
    do_req(0, 3'b010, 32'd13, 32'hC0000001, e, rd, lat); model_store(0, 3'b010, 32'd13, 32'hC0000001);
    n_vec++;
`ifdef ALIGN_CHECK_EN
    if ({e, rd, op_cnt - c0} !== {1'b1, 32'h0, 32'd0}) begin
      n_err++; $display("FAIL word_misalign got err=%b rd=%h ops=%0d want 1/0/0", e, rd, op_cnt - c0);
    end
`else
    if ({e, op_din, op_addr, op_cnt - c0} !== {1'b0, 32'hC0000001, 32'd13, 32'd1}) begin
      n_err++; $display("FAIL word_unaligned got err=%b din=%h addr=%h ops=%0d want 0/C0000001/d/1",
                        e, op_din, op_addr, op_cnt - c0);
    end
`endif
  endtask

  task automatic test_latency();
    logic e; logic [31:0] rd; int lat;
    moc_mode = 0; max_dly = 0;
    do_req(1, 3'b010, 32'd8, 32'h0, e, rd, lat);
    n_vec++;
    if ({lat, e, rd} !== {32'd4, 1'b0, model_load(32'd8, 3'b010)}) begin
      n_err++; $display("FAIL best_latency got lat=%0d err=%b rd=%h want 4/0/%h", lat, e, rd, model_load(32'd8, 3'b010));
    end
    @(negedge clk);
    n_vec++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      n_err++; $display("FAIL resp_pulse got valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_illegal_size();
    logic e; logic [31:0] rd; int lat, c0, r0;
    max_dly = 1;
    for (int k = 0; k < 2; k++) begin
      c0 = op_cnt; r0 = mov_rises;
      do_req(1'(k), {1'(k), 2'b11}, $urandom, $urandom, e, rd, lat);
      n_vec++;
      if ({e, rd, lat, op_cnt - c0, mov_rises - r0} !== {1'b1, 32'h0, 32'd1, 32'd0, 32'd0}) begin
        n_err++; $display("FAIL illegal_size%0d got err=%b rd=%h lat=%0d ops=%0d movs=%0d want 1/0/1/0/0",
                          k, e, rd, lat, op_cnt - c0, mov_rises - r0);
      end
    end
  endtask

  task automatic test_timeout();
    logic e; logic [31:0] rd; int lat, m0;
    moc_mode = 1; m0 = mov_cycles;
    do_req(1, 3'b010, 32'd20, 32'h0, e, rd, lat);
    n_vec++;
    if ({e, rd, mov_cycles - m0} !== {1'b1, 32'h0, 32'd16}) begin
      n_err++; $display("FAIL access_timeout got err=%b rd=%h movcyc=%0d want 1/0/16", e, rd, mov_cycles - m0);
    end
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL timeout_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_release_timeout();
    logic e; logic [31:0] rd; int lat, m0;
    moc_mode = 2; repeat (3) @(negedge clk);
    m0 = mov_cycles;
    do_req(1, 3'b000, 32'd3, 32'h0, e, rd, lat);
    n_vec++;
    if ({e, rd, mov_cycles - m0} !== {1'b1, 32'h0, 32'd1}) begin
      n_err++; $display("FAIL release_timeout got err=%b rd=%h movcyc=%0d want 1/0/1", e, rd, mov_cycles - m0);
    end
    moc_mode = 0; repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    logic e; logic [31:0] rd; int lat, n;
    moc_mode = 1;
    @(negedge clk);
    bus.req_valid = 1; bus.req_rw = 1; bus.req_size = 3'b010; bus.req_addr = 32'd40;
    n = 0;
    while (!bus.MOV && n < 20) begin @(negedge clk); bus.req_valid = 0; n++; end
    bus.req_valid = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_vec++;
    if ({n < 20, bus.MOV, bus.req_ready} !== 3'b101) begin
      n_err++; $display("FAIL reset_mid_access got reached=%b mov=%b ready=%b want 1/0/1", n < 20, bus.MOV, bus.req_ready);
    end
    @(negedge clk); rst_n = 1; moc_mode = 0;
    do_req(1, 3'b110, 32'd40, 32'h0, e, rd, lat);
    n_vec++;
    if ({e, rd} !== {exp_err(3'b110, 32'd40), model_load(32'd40, 3'b110)}) begin
      n_err++; $display("FAIL after_reset got %b/%h want 0/%h", e, rd, model_load(32'd40, 3'b110));
    end
  endtask

  task automatic test_random();
    logic e, rw, xe; logic [31:0] rd, a, wd, xr; logic [2:0] sz; int lat, c0;
    moc_mode = 0;
    for (int k = 0; k < 150; k++) begin
      max_dly = int'($urandom_range(0, 3));
      rw = 1'($urandom); sz = 3'($urandom_range(0, 7)); a = $urandom; wd = $urandom;
      if (k % 3 == 0) a[31:8] = '0;
      xe = exp_err(sz, a);
      xr = (xe || !rw) ? 32'h0 : model_load(a, sz);
      c0 = op_cnt;
      do_req(rw, sz, a, wd, e, rd, lat);
      n_vec++;
      if ({e, rd} !== {xe, xr}) begin
        n_err++; $display("FAIL rand%0d_resp rw=%b sz=%b a=%h got %b/%h want %b/%h", k, rw, sz, a, e, rd, xe, xr);
      end
      n_vec++;
      if (xe) begin
        if (op_cnt != c0) begin n_err++; $display("FAIL rand%0d_nomov got ops=%0d want 0", k, op_cnt - c0); end
      end else if ({op_cnt - c0, op_addr, op_ms, op_rw, rw ? 32'h0 : op_din} !==
                   {32'd1, a, {1'b0, sz[1:0]}, rw, rw ? 32'h0 : masked(wd, sz[1:0])}) begin
        n_err++; $display("FAIL rand%0d_bus got ops=%0d addr=%h ms=%b rw=%b din=%h want 1/%h/%b/%b/%h", k,
                          op_cnt - c0, op_addr, op_ms, op_rw, op_din, a, {1'b0, sz[1:0]}, rw, masked(wd, sz[1:0]));
      end
      model_store(rw, sz, a, wd);
    end
    n_vec++;
    if (unstable !== 0) begin n_err++; $display("FAIL bus_stable got %0d changes want 0", unstable); end
  endtask

  task automatic test_back_to_back();
    int acc, resp, n, r0;
    logic [31:0] a, xr;
    logic [2:0] sz;
    moc_mode = 0; max_dly = 1;
    sz = 3'($urandom_range(4, 6)); a = $urandom & 32'hFC;
    xr = model_load(a, sz);
    r0 = mov_rises; acc = 0; resp = 0; n = 0;
    @(negedge clk);
    bus.req_valid = 1; bus.req_rw = 1; bus.req_size = sz; bus.req_addr = a;
    while ((acc < 2 || resp < 2) && n < 200) begin
      if (bus.resp_valid) begin
        resp++;
        n_vec++;
        if ({bus.resp_err, bus.resp_rdata} !== {1'b0, xr}) begin
          n_err++; $display("FAIL b2b_resp%0d got %b/%h want 0/%h", resp, bus.resp_err, bus.resp_rdata, xr);
        end
      end
      if (bus.req_ready && bus.req_valid) acc++;
      @(negedge clk); n++;
      if (acc == 2) bus.req_valid = 0;
    end
    bus.req_valid = 0;
    n_vec++;
    if ({resp, mov_rises - r0} !== {32'd2, 32'd2}) begin
      n_err++; $display("FAIL b2b_count got resp=%0d movs=%0d want 2/2", resp, mov_rises - r0);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; moc_mode = 0; max_dly = 1; rst_n = 1;
    bus.req_valid = 0; bus.req_rw = 0; bus.req_size = 0; bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 37 + 11);
    test_reset();
    test_spec_vectors();
    test_latency();
    test_illegal_size();
    test_timeout();
    test_release_timeout();
    test_reset_mid_access();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
